cond_alu_exec: RTL and testbench
================================

// Module: cond_alu_exec
// PURPOSE
//  Multicycle ALU execute unit with registered carry/zero flags and cz-conditional execution (ADD/ADC/ADZ/ADL, NDU/NDC/NDZ).
//  Decodes aluop/funct/cz and computes LSB-first over SLICE_W-bit slices, one slice per clock.
//  Sits between the multicycle controller and the register-file writeback.
//  Flags live inside the block.
// PARAMETERS
//  WIDTH    16  datapath width in bits
//  SLICE_W  4   bits processed per cycle; WIDTH % SLICE_W == 0 is required
//  NSLICE   WIDTH/SLICE_W (localparam)  compute cycles per executed op
// PORTS
//  clk         in   1      clock; all state updates on the rising edge
//  reset       in   1      synchronous, active-high
//  start       in   1      request; sampled only when busy==0
//  aluop       in   2      00 add (address), 01 sub (compare), 10 R-type, 11 illegal
//  funct       in   1      R-type family: 0 add, 1 nand
//  cz          in   2      R-type condition/modifier field
//  a, b        in   WIDTH  operands; latched on an accepted start
//  busy        out  1      high in CALC
//  done        out  1      one-cycle pulse in FIN
//  result      out  WIDTH  last executed result; holds its value between ops
//  carry_flag  out  1      C register
//  zero_flag   out  1      Z register
//  skipped     out  1      valid with done: the condition was false and nothing was written
//  illegal     out  1      valid with done: the encoding was illegal and nothing was written
// BEHAVIOUR
//  Reset: state=IDLE, result=0, C=0, Z=0, done=busy=skipped=illegal=0.
//  FSM states: IDLE, CALC, FIN.
//   - IDLE/FIN with start=1: latch a, b, decode.
//     - Illegal or condition false: go to FIN.
//     - Otherwise go to CALC with slice counter=0.
//   - CALC: process slice[cnt]; carry chains through a register; zero accumulates as an AND of per-slice zero.
//     At cnt==NSLICE-1, go to FIN.
//   - FIN: done=1 for exactly one cycle; busy=0. A start in FIN is accepted, so ops run back-to-back.
//   - No start in FIN: go to IDLE.
//  start while busy is ignored; there is no queueing.
//  Latency: executed op, done at t+NSLICE+1; skipped or illegal, done at t+1 (t = accept edge).
//  Decode:
//   - aluop 00: a+b, cin=0. Unconditional; flags untouched.
//   - aluop 01: a+~b, cin=1. Unconditional; flags untouched.
//   - aluop 10, funct 0: cz 00 ADD; 10 ADC (execute iff C); 01 ADZ (execute iff Z); 11 ADL (a+(b<<1), unconditional). Writes C and Z.
//   - aluop 10, funct 1: cz 00 NDU; 10 NDC (execute iff C); 01 NDZ (execute iff Z); 11 illegal. Writes Z only.
//   - aluop 11: illegal.
//  Condition is evaluated on the flags present at the accept edge.
//  Arithmetic is WIDTH bits, modulo 2^WIDTH.
//   - C = carry out of the MSB slice.
//   - Z = (result == 0) over the full width.
//   - Flags and result update on the edge entering FIN and are visible in the FIN cycle.
//  Skipped/illegal: result, C and Z unchanged; skipped/illegal are high only in FIN.
//  Reset mid-CALC: abort; next cycle is IDLE; done never pulses; flags return to 0.
// CONFIGURATION
//  ALU_OVF_EN defined:
//   - Extra output port ovf (1 bit), a registered signed-overflow flag.
//   - Updated on executed aluop 00/01 and on R-type add ops; cleared by reset; unchanged on nand, skip and illegal.
//  ALU_OVF_EN undefined: no ovf port and no overflow logic.
// STRUCTURE
//  Shared package alu_pkg:
//   - aluop encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE)
//   - cz encodings (CZ_NONE, CZ_C, CZ_Z, CZ_L)
//   - FSM state typedef
//  Sub-module alu_slice (SLICE_W-bit add/nand with cin, cout, zero); one instance is reused every CALC cycle.
// TESTING (WIDTH=16, SLICE_W=4)
//  1. Reset held 2 cycles -> result=0000, C=0, Z=0, busy=0, done=0.
//  2. aluop=10 funct=0 cz=00 a=FFFF b=0001 -> busy high 4 cycles, done at t+5, result=0000, C=1, Z=1.
//  3. ADC with C=1: a=0003 b=0004 -> result=0007, C=0, Z=0.
//     Repeat ADC -> done at t+1, skipped=1, result=0007, flags unchanged.
//  4. aluop=01 a=0005 b=0005 -> result=0000, flags unchanged.
//     Then NDU a=FFFF b=FFFF -> result=0000, Z=1, C unchanged.
//  5. NAND cz=11, then aluop=11 -> each gives done at t+1, illegal=1, no state change.
//     start pulsed during CALC -> ignored.
//  6. reset during CALC slice 2 -> IDLE next cycle, no done pulse, C=Z=0.
//     With ALU_OVF_EN: 7FFF+0001 -> ovf=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the conditional ALU execute unit: aluop, cz modifier and FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ILL   = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    CZ_NONE = 2'b00,
    CZ_Z    = 2'b01,
    CZ_C    = 2'b10,
    CZ_L    = 2'b11
  } cz_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_e;

endpackage

// File: rtl/alu_slice.sv
// One W-bit slice of the execute datapath: add with carry-in, or nand, plus a slice-zero flag.
module alu_slice
  import alu_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  input  logic         nand_i,
  output logic [W-1:0] y_o,
  output logic         cout_o,
  output logic         zero_o
);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    if (nand_i) begin
      y_o    = ~(a_i & b_i);
      cout_o = 1'b0;
    end else begin
      y_o    = sum[W-1:0];
      cout_o = sum[W];
    end
    zero_o = (y_o == '0);
  end

endmodule

// File: rtl/cond_alu_exec.sv
// Multicycle conditional ALU execute unit, LSB-first over SLICE_W-bit slices with internal C/Z flags.
// Optional ALU_OVF_EN adds a registered signed-overflow flag output (ovf).
module cond_alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SLICE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic             funct,
  input  logic [1:0]       cz,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             skipped,
`ifdef ALU_OVF_EN
  output logic             ovf,
`endif
  output logic             illegal
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, acc_q, result_q, res_next;
  logic [CW-1:0]      cnt_q;
  logic               carry_q, zacc_q, nand_q, wc_q, wz_q;
  logic               c_q, z_q, done_q, skipped_q, illegal_q;

  logic               dec_ill, dec_exec, dec_cin, dec_nand, dec_wc, dec_wz;
  logic [WIDTH-1:0]   dec_b;

  logic [SLICE_W-1:0] sl_y;
  logic               sl_cout, sl_zero;

`ifdef ALU_OVF_EN
  logic dec_wo, wo_q, ovf_q;
  assign dec_wo = (aluop == ALUOP_ADD) || (aluop == ALUOP_SUB) ||
                  ((aluop == ALUOP_RTYPE) && !funct);
  assign ovf    = ovf_q;
`endif

  // Operand b is pre-conditioned at accept (invert for sub, shift for ADL) so CALC is uniform.
  always_comb begin
    dec_ill  = 1'b0;
    dec_exec = 1'b1;
    dec_cin  = 1'b0;
    dec_nand = 1'b0;
    dec_wc   = 1'b0;
    dec_wz   = 1'b0;
    dec_b    = b;
    case (aluop_e'(aluop))
      ALUOP_ADD: ;
      ALUOP_SUB: begin
        dec_b   = ~b;
        dec_cin = 1'b1;
      end
      ALUOP_RTYPE: begin
        dec_nand = funct;
        dec_wc   = ~funct;
        dec_wz   = 1'b1;
        case (cz_e'(cz))
          CZ_C:    dec_exec = c_q;
          CZ_Z:    dec_exec = z_q;
          CZ_L:    if (funct) dec_ill = 1'b1; else dec_b = b << 1;
          default: ;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  alu_slice #(.W(SLICE_W)) u_slice (
    .a_i    (a_q[SLICE_W-1:0]),
    .b_i    (b_q[SLICE_W-1:0]),
    .cin_i  (carry_q),
    .nand_i (nand_q),
    .y_o    (sl_y),
    .cout_o (sl_cout),
    .zero_o (sl_zero)
  );

  // Operands shift right each cycle; result slices enter at the top so slice 0 lands at the LSB.
  assign res_next = (acc_q >> SLICE_W) | (WIDTH'(sl_y) << (WIDTH - SLICE_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      zacc_q    <= 1'b0;
      nand_q    <= 1'b0;
      wc_q      <= 1'b0;
      wz_q      <= 1'b0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      done_q    <= 1'b0;
      skipped_q <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_OVF_EN
      wo_q      <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      skipped_q <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_CALC: begin
          a_q     <= a_q >> SLICE_W;
          b_q     <= b_q >> SLICE_W;
          acc_q   <= res_next;
          carry_q <= sl_cout;
          zacc_q  <= zacc_q & sl_zero;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(NSLICE - 1)) begin
            state_q  <= S_FIN;
            done_q   <= 1'b1;
            result_q <= res_next;
            if (wc_q) c_q <= sl_cout;
            if (wz_q) z_q <= zacc_q & sl_zero;
`ifdef ALU_OVF_EN
            if (wo_q) ovf_q <= (a_q[SLICE_W-1] == b_q[SLICE_W-1]) &&
                               (sl_y[SLICE_W-1] != a_q[SLICE_W-1]);
`endif
          end
        end
        default: begin
          if (start) begin
            a_q     <= a;
            b_q     <= dec_b;
            nand_q  <= dec_nand;
            carry_q <= dec_cin;
            zacc_q  <= 1'b1;
            cnt_q   <= '0;
            wc_q    <= dec_wc;
            wz_q    <= dec_wz;
`ifdef ALU_OVF_EN
            wo_q    <= dec_wo;
`endif
            if (dec_ill) begin
              state_q   <= S_FIN;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end else if (!dec_exec) begin
              state_q   <= S_FIN;
              done_q    <= 1'b1;
              skipped_q <= 1'b1;
            end else begin
              state_q <= S_CALC;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy       = (state_q == S_CALC);
  assign done       = done_q;
  assign result     = result_q;
  assign carry_flag = c_q;
  assign zero_flag  = z_q;
  assign skipped    = skipped_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_cond_alu_exec.sv
// Directed bench for cond_alu_exec (WIDTH=16, SLICE_W=4); covers ovf when ALU_OVF_EN is defined.
module tb_cond_alu_exec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic        funct = 1'b0;
  logic [1:0]  cz = 2'b00;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, carry_flag, zero_flag, skipped, illegal;
  logic [15:0] result;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_alu_exec #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .aluop      (aluop),
    .funct      (funct),
    .cz         (cz),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .skipped    (skipped),
`ifdef ALU_OVF_EN
    .ovf        (ovf),
`endif
    .illegal    (illegal)
  );

  // Raises start now, drops it after the accept edge; lat = edges until done (1 = accept edge).
  task automatic run(input logic [1:0] op, input logic f, input logic [1:0] c,
                     input logic [15:0] aa, input logic [15:0] bb,
                     output int lat, output int bcnt);
    aluop = op; funct = f; cz = c; a = aa; b = bb; start = 1'b1;
    lat = 99; bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({result, carry_flag, zero_flag, busy, done, skipped, illegal} !== {16'h0000, 6'b000000}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h",
               {result, carry_flag, zero_flag, busy, done, skipped, illegal}, {16'h0000, 6'b000000});
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_add_wrap;
    int lat, bc;
    @(negedge clk);
    run(2'b10, 1'b0, 2'b00, 16'hFFFF, 16'h0001, lat, bc);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL add_latency: got %0d expected 5", lat); end
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL add_busy_cycles: got %0d expected 4", bc); end
    checks++;
    if ({result, carry_flag, zero_flag, skipped, illegal} !== {16'h0000, 4'b1100}) begin
      errors++;
      $display("FAIL add_wrap: got %h expected %h",
               {result, carry_flag, zero_flag, skipped, illegal}, {16'h0000, 4'b1100});
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
  endtask

  task automatic test_adc;
    int lat, bc;
    @(negedge clk);
    run(2'b10, 1'b0, 2'b10, 16'h0003, 16'h0004, lat, bc);
    checks++;
    if ({lat[3:0], result, carry_flag, zero_flag, skipped} !== {4'd5, 16'h0007, 3'b000}) begin
      errors++;
      $display("FAIL adc_exec: got %h expected %h",
               {lat[3:0], result, carry_flag, zero_flag, skipped}, {4'd5, 16'h0007, 3'b000});
    end
    @(negedge clk);
    run(2'b10, 1'b0, 2'b10, 16'h0003, 16'h0004, lat, bc);
    checks++;
    if ({lat[3:0], result, carry_flag, zero_flag, skipped, illegal} !== {4'd1, 16'h0007, 4'b0010}) begin
      errors++;
      $display("FAIL adc_skip: got %h expected %h",
               {lat[3:0], result, carry_flag, zero_flag, skipped, illegal}, {4'd1, 16'h0007, 4'b0010});
    end
  endtask

  task automatic test_sub_nand_misc;
    int lat, bc;
    @(negedge clk);
    run(2'b01, 1'b0, 2'b00, 16'h0005, 16'h0005, lat, bc);
    checks++;
    if ({lat[3:0], result, carry_flag, zero_flag} !== {4'd5, 16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL sub_flags_kept: got %h expected %h",
               {lat[3:0], result, carry_flag, zero_flag}, {4'd5, 16'h0000, 2'b00});
    end
    @(negedge clk);
    run(2'b10, 1'b1, 2'b00, 16'hFFFF, 16'hFFFF, lat, bc);
    checks++;
    if ({result, carry_flag, zero_flag} !== {16'h0000, 2'b01}) begin
      errors++;
      $display("FAIL ndu: got %h expected %h", {result, carry_flag, zero_flag}, {16'h0000, 2'b01});
    end
    @(negedge clk);
    run(2'b10, 1'b1, 2'b01, 16'h00F0, 16'h0F0F, lat, bc);
    checks++;
    if ({lat[3:0], result, carry_flag, zero_flag} !== {4'd5, 16'hFFFF, 2'b00}) begin
      errors++;
      $display("FAIL ndz_exec: got %h expected %h",
               {lat[3:0], result, carry_flag, zero_flag}, {4'd5, 16'hFFFF, 2'b00});
    end
    @(negedge clk);
    run(2'b10, 1'b0, 2'b01, 16'h1111, 16'h1111, lat, bc);
    checks++;
    if ({lat[3:0], result, skipped} !== {4'd1, 16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL adz_skip: got %h expected %h", {lat[3:0], result, skipped}, {4'd1, 16'hFFFF, 1'b1});
    end
    @(negedge clk);
    run(2'b10, 1'b0, 2'b11, 16'h0001, 16'h0003, lat, bc);
    checks++;
    if ({result, carry_flag, zero_flag} !== {16'h0007, 2'b00}) begin
      errors++;
      $display("FAIL adl: got %h expected %h", {result, carry_flag, zero_flag}, {16'h0007, 2'b00});
    end
    @(negedge clk);
    run(2'b00, 1'b0, 2'b00, 16'h1234, 16'h1111, lat, bc);
    checks++;
    if ({result, carry_flag, zero_flag} !== {16'h2345, 2'b00}) begin
      errors++;
      $display("FAIL addr_add: got %h expected %h", {result, carry_flag, zero_flag}, {16'h2345, 2'b00});
    end
  endtask

  task automatic test_illegal;
    int lat, bc;
    @(negedge clk);
    run(2'b10, 1'b1, 2'b11, 16'hAAAA, 16'h5555, lat, bc);
    checks++;
    if ({lat[3:0], result, carry_flag, zero_flag, skipped, illegal} !== {4'd1, 16'h2345, 4'b0001}) begin
      errors++;
      $display("FAIL illegal_nand_cz11: got %h expected %h",
               {lat[3:0], result, carry_flag, zero_flag, skipped, illegal}, {4'd1, 16'h2345, 4'b0001});
    end
    @(negedge clk);
    run(2'b11, 1'b0, 2'b00, 16'h0001, 16'h0001, lat, bc);
    checks++;
    if ({lat[3:0], result, carry_flag, zero_flag, skipped, illegal} !== {4'd1, 16'h2345, 4'b0001}) begin
      errors++;
      $display("FAIL illegal_aluop11: got %h expected %h",
               {lat[3:0], result, carry_flag, zero_flag, skipped, illegal}, {4'd1, 16'h2345, 4'b0001});
    end
  endtask

  task automatic test_start_while_busy;
    int lat = 99;
    int extra = 0;
    @(negedge clk);
    aluop = 2'b00; funct = 1'b0; cz = 2'b00; a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    if (done) lat = 2;
    for (int i = 3; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (lat == 99) lat = i; else extra++;
      end
    end
    checks++;
    if ({lat[3:0], result} !== {4'd5, 16'h0002}) begin
      errors++;
      $display("FAIL start_in_calc_ignored: got %h expected %h", {lat[3:0], result}, {4'd5, 16'h0002});
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL no_queued_op: got %0d extra done expected 0", extra); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    @(negedge clk);
    run(2'b00, 1'b0, 2'b00, 16'h0002, 16'h0003, lat, bc);
    checks++;
    if (result !== 16'h0005) begin errors++; $display("FAIL b2b_first: got %h expected 0005", result); end
    run(2'b01, 1'b0, 2'b00, 16'h0009, 16'h0002, lat, bc);
    checks++;
    if ({lat[3:0], result} !== {4'd5, 16'h0007}) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h", {lat[3:0], result}, {4'd5, 16'h0007});
    end
  endtask

  task automatic test_reset_mid_calc;
    int lat, bc;
    int seen = 0;
    @(negedge clk);
    run(2'b10, 1'b0, 2'b00, 16'hFFFF, 16'h0001, lat, bc);
    checks++;
    if ({carry_flag, zero_flag} !== 2'b11) begin
      errors++;
      $display("FAIL pre_abort_flags: got %b expected 11", {carry_flag, zero_flag});
    end
    @(negedge clk);
    aluop = 2'b10; funct = 1'b0; cz = 2'b00; a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, carry_flag, zero_flag, result} !== {4'b0000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_abort: got %h expected %h",
               {busy, done, carry_flag, zero_flag, result}, {4'b0000, 16'h0000});
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
  endtask

`ifdef ALU_OVF_EN
  task automatic test_ovf;
    int lat, bc;
    @(negedge clk);
    run(2'b00, 1'b0, 2'b00, 16'h7FFF, 16'h0001, lat, bc);
    checks++;
    if ({ovf, result} !== {1'b1, 16'h8000}) begin
      errors++;
      $display("FAIL ovf_set: got %h expected %h", {ovf, result}, {1'b1, 16'h8000});
    end
    @(negedge clk);
    run(2'b10, 1'b1, 2'b00, 16'h0001, 16'h0001, lat, bc);
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_kept_on_nand: got %b expected 1", ovf); end
    @(negedge clk);
    run(2'b01, 1'b0, 2'b00, 16'h0003, 16'h0001, lat, bc);
    checks++;
    if ({ovf, result} !== {1'b0, 16'h0002}) begin
      errors++;
      $display("FAIL ovf_clear_sub: got %h expected %h", {ovf, result}, {1'b0, 16'h0002});
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add_wrap();
    test_adc();
    test_sub_nand_misc();
    test_illegal();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_calc();
`ifdef ALU_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
